// File: rtl/mul_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_sequencer
// Brief    : Multi-cycle MUL/MLA controller that borrows the execute ALU for
//            a shift-and-add multiply and stalls the pipeline while it runs.
// Revision : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
    parameter int WORD_LEN = 32,
    parameter int CNT_W    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                is_mla,
    input  logic [WORD_LEN-1:0] rm,
    input  logic [WORD_LEN-1:0] rs,
    input  logic [WORD_LEN-1:0] rn,
    input  logic                flush,
    input  logic [WORD_LEN-1:0] alu_res,
    output logic [3:0]          alu_cmd,
    output logic [WORD_LEN-1:0] alu_val1,
    output logic [WORD_LEN-1:0] alu_val2,
    output logic                alu_c_in,
    output logic                alu_own,
    output logic                busy,
    output logic                stall,
    output logic                done,
    output logic [WORD_LEN-1:0] result,
    output logic                n_flag,
    output logic                z_flag
);

    localparam logic [3:0]       c_CMD_MOV   = 4'b0001;
    localparam logic [3:0]       c_CMD_ADD   = 4'b0010;
    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WORD_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WORD_LEN-1:0] r_acc;
    logic [WORD_LEN-1:0] r_mcand;
    logic [WORD_LEN-1:0] r_mplier;
    logic [WORD_LEN-1:0] r_rn;
    logic                r_is_mla;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORD_LEN-1:0] r_result;
    logic [WORD_LEN-1:0] w_acc_nxt;
    logic [WORD_LEN-1:0] w_mplier_sh;

    assign w_mplier_sh = r_mplier >> 1;

    always_comb begin
        w_next    = r_state;
        w_acc_nxt = r_acc;
        alu_cmd   = 4'b0000;
        alu_val1  = '0;
        alu_val2  = '0;
        alu_own   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) w_next = S_INIT;
            end
            S_INIT: begin
                alu_own   = 1'b1;
                alu_cmd   = c_CMD_MOV;
                alu_val2  = r_is_mla ? r_rn : '0;
                w_acc_nxt = alu_res;
                w_next    = (r_mplier == '0) ? S_DONE : S_ITER;
            end
            S_ITER: begin
                alu_own = 1'b1;
                if (r_mplier[0]) begin
                    alu_cmd   = c_CMD_ADD;
                    alu_val1  = r_acc;
                    alu_val2  = r_mcand;
                    w_acc_nxt = alu_res;
                end else begin
                    alu_cmd  = c_CMD_MOV;
                    alu_val2 = r_acc;
                end
                if (w_mplier_sh == '0 || r_cnt == c_LAST_STEP) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rn     <= '0;
            r_is_mla <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (!flush) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_mcand  <= rm;
                            r_mplier <= rs;
                            r_rn     <= rn;
                            r_is_mla <= is_mla;
                            r_cnt    <= '0;
                        end
                    end
                    S_INIT: r_acc <= w_acc_nxt;
                    S_ITER: begin
                        r_acc    <= w_acc_nxt;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= w_mplier_sh;
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                    S_DONE: r_result <= r_acc;
                    default: ;
                endcase
            end
        end
    end

    // The product is presented straight from acc during DONE and committed at
    // its end, so a flush in DONE leaves the previous result and flags intact.
    assign done     = (r_state == S_DONE) && !flush;
    assign result   = done ? r_acc : r_result;
    assign n_flag   = result[WORD_LEN-1];
    assign z_flag   = (result == '0);
    assign busy     = (r_state != S_IDLE);
    assign stall    = ((r_state == S_IDLE) && start) || (r_state == S_INIT) || (r_state == S_ITER);
    assign alu_c_in = 1'b0;

endmodule
`default_nettype wire
